vending_credit_fsm: RTL and testbench

//  Parametrised successor of the coin-accumulating Moore vending FSM. Accepts coins

---
 rtl/vend_pkg.sv | 11 +
 rtl/vending_credit_fsm.sv | 81 ++++++++
 tb/tb_vending_credit_fsm.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, coin codes and coin valuation for the vending credit FSM.
package vend_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN1 = 2'd1;
    localparam logic [1:0] COIN2 = 2'd2;
    localparam logic [1:0] COIN3 = 2'd3;
    function automatic int unsigned coin_value(logic [1:0] code, int unsigned v1, int unsigned v2, int unsigned v3);
        return code == COIN1 ? v1 : code == COIN2 ? v2 : code == COIN3 ? v3 : 0;
    endfunction
endpackage

// File: rtl/vending_credit_fsm.sv
// vending_credit_fsm: coin-accumulating Moore vending FSM with vend and change req/ack handshakes.
module vending_credit_fsm
    import vend_pkg::*;
#(
    parameter int unsigned PRICE = 7,
    parameter int unsigned MAX_CREDIT = 15,
    parameter int unsigned COIN1_VAL = 1,
    parameter int unsigned COIN2_VAL = 2,
    parameter int unsigned COIN3_VAL = 5,
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject
);
    state_t state, state_nx;
    logic [CREDIT_W-1:0] credit_nx, amt_nx;
    logic accept, refund;
    int unsigned sum;
    always_comb begin
        sum = int'(credit) + coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL);
        refund = cancel && state == ACCUM;
        accept = coin_valid && (state == IDLE || state == ACCUM) && coin != COIN_NONE
                 && sum <= MAX_CREDIT && !refund;
        state_nx = state;
        credit_nx = credit;
        amt_nx = change_amt;
        case (state)
            IDLE, ACCUM: begin
                if (refund) begin
                    state_nx = CHANGE;
                    amt_nx = credit;
                    credit_nx = '0;
                end else if (accept) begin
                    credit_nx = CREDIT_W'(sum);
                    state_nx = sum >= PRICE ? VEND : ACCUM;
                end
            end
            VEND: begin
                if (vend_ack) begin
                    // credit >= PRICE is guaranteed here, so the subtraction cannot underflow
                    amt_nx = credit - CREDIT_W'(PRICE);
                    credit_nx = '0;
                    state_nx = credit == CREDIT_W'(PRICE) ? IDLE : CHANGE;
                end
            end
            default: begin
                if (change_ack) begin
                    state_nx = IDLE;
                    amt_nx = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            credit <= '0;
            change_amt <= '0;
            coin_reject <= 1'b0;
            vend_req <= 1'b0;
            change_valid <= 1'b0;
        end else begin
            state <= state_nx;
            credit <= credit_nx;
            change_amt <= amt_nx;
            coin_reject <= coin_valid && !accept;
            vend_req <= state_nx == VEND;
            change_valid <= state_nx == CHANGE;
        end
    end
endmodule

// File: tb/tb_vending_credit_fsm.sv
// tb_vending_credit_fsm: directed and random stimulus on two parameterisations against a credit-ledger model.
module tb_vending_credit_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, coin_valid, cancel, vend_ack, change_ack;
    logic [1:0] coin;
    logic [3:0] credit [2];
    logic [3:0] change_amt [2];
    logic vend_req [2], change_valid [2], coin_reject [2];
    int vectors = 0, miscompares = 0;
    int max_c [2] = '{15, 10};
    int m_credit [2], m_change [2];
    bit m_vending [2], m_reject [2];

    vending_credit_fsm u_dflt (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
        .vend_ack(vend_ack), .change_ack(change_ack), .credit(credit[0]), .vend_req(vend_req[0]),
        .change_valid(change_valid[0]), .change_amt(change_amt[0]), .coin_reject(coin_reject[0])
    );
    vending_credit_fsm #(.MAX_CREDIT(10)) u_max10 (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
        .vend_ack(vend_ack), .change_ack(change_ack), .credit(credit[1]), .vend_req(vend_req[1]),
        .change_valid(change_valid[1]), .change_amt(change_amt[1]), .coin_reject(coin_reject[1])
    );

    function automatic int value_of(logic [1:0] k);
        return k == 2'd1 ? 1 : k == 2'd2 ? 2 : k == 2'd3 ? 5 : 0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ledger view: credit held, whether a vend is pending, change owed (0 = none owed).
    task automatic model();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_credit[i] = 0; m_change[i] = 0; m_vending[i] = 0; m_reject[i] = 0;
            end else if (m_vending[i]) begin
                m_reject[i] = coin_valid;
                if (vend_ack) begin
                    m_change[i] = m_credit[i] - 7; m_credit[i] = 0; m_vending[i] = 0;
                end
            end else if (m_change[i] > 0) begin
                m_reject[i] = coin_valid;
                if (change_ack) m_change[i] = 0;
            end else if (cancel && m_credit[i] > 0) begin
                m_reject[i] = coin_valid;
                m_change[i] = m_credit[i]; m_credit[i] = 0;
            end else if (coin_valid) begin
                if (coin != 2'd0 && m_credit[i] + value_of(coin) <= max_c[i]) begin
                    m_reject[i] = 0;
                    m_credit[i] += value_of(coin);
                    m_vending[i] = m_credit[i] >= 7;
                end else m_reject[i] = 1;
            end else m_reject[i] = 0;
        end
    endtask

    task automatic step(bit r, bit cv, logic [1:0] k, bit cn, bit va, bit ca);
        rst_n = r; coin_valid = cv; coin = k; cancel = cn; vend_ack = va; change_ack = ca;
        @(posedge clk);
        model();
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d credit", i), credit[i], m_credit[i]);
            check($sformatf("u%0d vend_req", i), vend_req[i], m_vending[i]);
            check($sformatf("u%0d change_valid", i), change_valid[i], m_change[i] > 0);
            check($sformatf("u%0d change_amt", i), change_amt[i], m_change[i]);
            check($sformatf("u%0d coin_reject", i), coin_reject[i], m_reject[i]);
        end
    endtask

    task automatic idle(int n);
        for (int j = 0; j < n; j++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 1, 1, 1);
        check("reset credit", credit[0], 0);
        check("reset vend_req", vend_req[0], 0);
        // two coins reaching exactly the price
        step(1, 1, 2, 0, 0, 0);
        check("t1 credit2", credit[0], 2);
        step(1, 1, 3, 0, 0, 0);
        check("t1 credit7", credit[0], 7);
        check("t1 vend_req", vend_req[0], 1);
        idle(2);
        step(1, 0, 0, 0, 1, 0);
        check("t1 idle credit", credit[0], 0);
        check("t1 no change", change_valid[0], 0);
        idle(1);
        // overpay, then change handshake
        step(1, 1, 3, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        check("t2 credit10", credit[0], 10);
        step(1, 0, 0, 0, 1, 0);
        check("t2 change_valid", change_valid[0], 1);
        check("t2 change_amt", change_amt[0], 3);
        idle(2);
        step(1, 0, 0, 0, 0, 1);
        check("t2 cleared", change_amt[0], 0);
        // cancel beats a simultaneous coin
        step(1, 1, 2, 0, 0, 0);
        step(1, 1, 3, 1, 0, 0);
        check("t3 reject", coin_reject[0], 1);
        check("t3 refund", change_amt[0], 2);
        check("t3 no vend", vend_req[0], 0);
        step(1, 0, 0, 0, 0, 1);
        // MAX_CREDIT ceiling on the second instance
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        check("t4 max reject", coin_reject[1], 1);
        check("t4 max credit", credit[1], 6);
        check("t4 dflt credit11", credit[0], 11);
        step(1, 1, 0, 0, 0, 0);
        check("t4 code0 reject", coin_reject[1], 1);
        step(1, 0, 0, 1, 1, 0);
        check("t4 dflt change", change_amt[0], 4);
        check("t4 max refund", change_amt[1], 6);
        step(1, 0, 0, 0, 0, 1);
        // coin and cancel while vending
        step(1, 1, 2, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        check("t5 reject", coin_reject[0], 1);
        check("t5 credit", credit[0], 7);
        step(1, 0, 0, 1, 0, 0);
        check("t5 still vend", vend_req[0], 1);
        step(1, 1, 1, 0, 1, 0);
        check("t5 ack coin rej", coin_reject[0], 1);
        // reset abandons a pending change
        step(1, 1, 3, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        check("t6 change3", change_amt[0], 3);
        step(0, 0, 0, 0, 0, 0);
        check("t6 change_valid", change_valid[0], 0);
        check("t6 change_amt", change_amt[0], 0);
        check("t6 credit", credit[0], 0);
        for (int n = 0; n < 800; n++)
            step($urandom_range(0, 59) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
